uart_word: RTL and testbench
============================

Name: uart_word

Overview:
- UART 8N1 receiver that assembles four consecutive bytes into one 32-bit word.
- Sits between the board RX pin and the bootloader, which consumes words (program length, data addresses and values, SP, PC, instructions) one `rdata_ready` pulse at a time.
- Single clock domain. The `rxd` pin is asynchronous and is synchronised internally.

Parameters:
- CLK_PER_HALF_BIT, default 5208: clk cycles per half UART bit. One bit period is 2*CLK_PER_HALF_BIT cycles. Legal range is 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- rdata  output  32  last completed word; the first received byte lands in [7:0], the fourth in [31:24].
- rdata_ready  output  1  one-cycle pulse when rdata has just been updated with a new word.
- ferr  output  1  one-cycle pulse when a byte's stop bit is sampled low.
- rxd  input  1  serial line, idle high, LSB first.
- Declaration order is fixed for positional instantiation: rdata, rdata_ready, ferr, rxd, clk, reset.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset=0:
  - rdata=0, rdata_ready=0, ferr=0.
  - Byte counter = 0, shift register = 0, receiver state = IDLE, baud counter = 0.
  - Both rxd synchroniser flops = 1.
  - Asserting reset mid-byte or mid-word discards all partial data. After release, reception starts only at the next falling edge.
- Synchroniser: two flops on rxd; all logic uses the second flop (rxs). This adds 2 cycles of input latency.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rxs=0, go to START and clear the baud counter.
  - START: after CLK_PER_HALF_BIT cycles (mid start bit), sample rxs.
    - If rxs=1: false start (glitch), return to IDLE with no output.
    - If rxs=0: go to DATA with bit index 0.
  - DATA: every 2*CLK_PER_HALF_BIT cycles, sample rxs into bit[index], LSB first. After bit 7, go to STOP.
  - STOP: 2*CLK_PER_HALF_BIT cycles after bit 7, sample rxs, then return to IDLE in the same cycle. Returning at mid stop bit allows back-to-back frames.
- Word assembly on a good stop bit (rxs=1):
  - Write the byte into lane [8*cnt+7 : 8*cnt] of the word shift register.
  - cnt increments modulo 4.
  - When cnt was 3: on the next clk edge rdata <= complete word and rdata_ready=1 for exactly one cycle; cnt returns to 0.
  - rdata holds its value until the next complete word.
- Framing error on a bad stop bit (rxs=0):
  - ferr=1 for exactly one cycle.
  - The byte is discarded and cnt resets to 0, so any partial word is dropped.
  - The FSM returns to IDLE. If rxd is still low, the next cycle counts as a new start edge, which is acceptable.
- Latency: rdata_ready rises 1 cycle after the mid-stop sample of the 4th byte, i.e. about 2 + 19*CLK_PER_HALF_BIT + 1 cycles after that byte's start edge.
- rdata_ready and ferr are never asserted in the same cycle.
- No receive buffering: the consumer must take rdata before the next word completes (at least 4 byte times).
- Counters are sized to hold 2*CLK_PER_HALF_BIT-1 without overflow.

Test Plan:
- Send bytes 0x78, 0x56, 0x34, 0x12 at CLK_PER_HALF_BIT=4 -> exactly one rdata_ready pulse, rdata=0x12345678, ferr never set.
- Two back-to-back words 0xFFFFFFFF then 0x00000004 (stop bit one bit long) -> two single-cycle pulses with rdata=0xFFFFFFFF then 0x00000004.
- rxd low-pulse of 2 cycles, then idle; then a valid word 0xDEADBEEF -> no pulse from the glitch; one rdata_ready pulse with rdata=0xDEADBEEF.
- Byte 0x11 with stop=0, then four good bytes 0x01..0x04 -> one ferr pulse; then rdata=0x04030201, with no stale 0x11 anywhere in the word.
- Two bytes sent, reset pulsed low mid third byte, then a full word 0xCAFEBABE -> outputs 0 during reset; afterwards rdata=0xCAFEBABE.
- Sample-timing check: send 0x55 where bits are skewed ±(CLK_PER_HALF_BIT/2 - 1) cycles -> byte still decoded correctly (mid-bit sampling).

Source files
------------

// File: rtl/uart_word.sv
// UART 8N1 receiver that packs four consecutive bytes, first byte in [7:0], into a 32-bit word.
// A bad stop bit pulses ferr and drops any partial word.
module uart_word #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
  output logic [31:0] rdata,
  output logic        rdata_ready,
  output logic        ferr,
  input  logic        rxd,
  input  logic        clk,
  input  logic        reset
);

  localparam int unsigned BitCycles = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned CntW      = $clog2(BitCycles);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic              rxd_meta_q, rxs_q;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        byte_q, byte_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdata_ready_q, rdata_ready_d;
  logic              ferr_q, ferr_d;
  logic              stop_good, stop_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q    <= 1'b1;
      rxs_q         <= 1'b1;
      state_q       <= StIdle;
      baud_q        <= '0;
      bit_idx_q     <= '0;
      byte_q        <= '0;
      word_q        <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_ready_q <= 1'b0;
      ferr_q        <= 1'b0;
    end else begin
      rxd_meta_q    <= rxd;
      rxs_q         <= rxd_meta_q;
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_idx_q     <= bit_idx_d;
      byte_q        <= byte_d;
      word_q        <= word_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      rdata_ready_q <= rdata_ready_d;
      ferr_q        <= ferr_d;
    end
  end

  // Byte framing: mid-start check, then one sample per bit period at mid-bit.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (baud_q == HalfLast) begin
          baud_d = '0;
          if (rxs_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (baud_q == BitLast) begin
          baud_d    = '0;
          byte_d    = {rxs_q, byte_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StStop: begin
        if (baud_q == BitLast) begin
          baud_d    = '0;
          state_d   = StIdle;
          stop_good = rxs_q;
          stop_bad  = ~rxs_q;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Word assembly and output pulses.
  always_comb begin
    word_d        = word_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    rdata_ready_d = 1'b0;
    ferr_d        = 1'b0;
    if (stop_good) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_q;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        rdata_d       = {byte_q, word_q[23:0]};
        rdata_ready_d = 1'b1;
      end
    end else if (stop_bad) begin
      ferr_d = 1'b1;
      cnt_d  = '0;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_ready = rdata_ready_q;
  assign ferr        = ferr_q;

endmodule

// File: tb/tb_uart_word.sv
// Bench for uart_word: table of frames with expected pulses/word, hand corner cases,
// then random frames checked against a byte-queue model.
module tb_uart_word;

  localparam int unsigned H = 4;

  logic [31:0] rdata;
  logic        rdata_ready;
  logic        ferr;
  logic        rxd;
  logic        clk;
  logic        reset;

  uart_word #(.CLK_PER_HALF_BIT(H)) dut (
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr),
    .rxd         (rxd),
    .clk         (clk),
    .reset       (reset)
  );

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int          skew;
    int          gap;
    int          exp_ready;
    int          exp_ferr;
    logic [31:0] exp_word;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int ready_cnt = 0;
  int ferr_cnt = 0;
  logic [31:0] cur_word = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Count pulse cycles; ready and ferr must never coincide.
  always @(negedge clk) begin
    if (reset) begin
      if (rdata_ready) ready_cnt++;
      if (ferr) ferr_cnt++;
      if (rdata_ready || ferr) check("pulse_overlap", {31'd0, rdata_ready & ferr}, 32'd0);
    end
  end

  // Bit lengths alternate 2H+skew / 2H-skew so boundaries drift by up to skew cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int skew);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (2 * H + ((i % 2 == 0) ? skew : -skew)) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    int r0, f0;
    r0 = ready_cnt;
    f0 = ferr_cnt;
    send_frame(v.data, v.stop, v.skew);
    repeat (v.gap) @(negedge clk);
    check("ready_pulses", 32'(ready_cnt - r0), 32'(v.exp_ready));
    check("ferr_pulses", 32'(ferr_cnt - f0), 32'(v.exp_ferr));
    check("rdata", rdata, v.exp_word);
    cur_word = v.exp_word;
  endtask

  vec_t vecs[$];
  logic [7:0] model_q[$];

  initial begin
    int r0, f0;
    logic [7:0] cb[4];
    rxd   = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_ready", {31'd0, rdata_ready}, 32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // data, stop, skew, gap, exp_ready, exp_ferr, exp_word
    vecs.push_back('{8'h78, 1'b1, 0, 8, 0, 0, 32'h0});
    vecs.push_back('{8'h56, 1'b1, 0, 8, 0, 0, 32'h0});
    vecs.push_back('{8'h34, 1'b1, 0, 8, 0, 0, 32'h0});
    vecs.push_back('{8'h12, 1'b1, 0, 8, 1, 0, 32'h12345678});
    vecs.push_back('{8'hFF, 1'b1, 0, 0, 0, 0, 32'h12345678});
    vecs.push_back('{8'hFF, 1'b1, 0, 0, 0, 0, 32'h12345678});
    vecs.push_back('{8'hFF, 1'b1, 0, 0, 0, 0, 32'h12345678});
    vecs.push_back('{8'hFF, 1'b1, 0, 0, 1, 0, 32'hFFFFFFFF});
    vecs.push_back('{8'h04, 1'b1, 0, 0, 0, 0, 32'hFFFFFFFF});
    vecs.push_back('{8'h00, 1'b1, 0, 0, 0, 0, 32'hFFFFFFFF});
    vecs.push_back('{8'h00, 1'b1, 0, 0, 0, 0, 32'hFFFFFFFF});
    vecs.push_back('{8'h00, 1'b1, 0, 8, 1, 0, 32'h00000004});
    vecs.push_back('{8'h11, 1'b0, 0, 16, 0, 1, 32'h00000004});
    vecs.push_back('{8'h01, 1'b1, 0, 8, 0, 0, 32'h00000004});
    vecs.push_back('{8'h02, 1'b1, 0, 8, 0, 0, 32'h00000004});
    vecs.push_back('{8'h03, 1'b1, 0, 8, 0, 0, 32'h00000004});
    vecs.push_back('{8'h04, 1'b1, 0, 8, 1, 0, 32'h04030201});
    vecs.push_back('{8'h55, 1'b1, 1, 8, 0, 0, 32'h04030201});
    vecs.push_back('{8'h55, 1'b1, -1, 8, 0, 0, 32'h04030201});
    vecs.push_back('{8'h55, 1'b1, 1, 0, 0, 0, 32'h04030201});
    vecs.push_back('{8'h55, 1'b1, -1, 8, 1, 0, 32'h55555555});
    foreach (vecs[i]) apply(vecs[i]);

    // Short low glitch must be rejected as a false start.
    r0 = ready_cnt;
    f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_ready", 32'(ready_cnt - r0), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_rdata", rdata, 32'h55555555);
    apply('{8'hEF, 1'b1, 0, 8, 0, 0, 32'h55555555});
    apply('{8'hBE, 1'b1, 0, 8, 0, 0, 32'h55555555});
    apply('{8'hAD, 1'b1, 0, 8, 0, 0, 32'h55555555});
    apply('{8'hDE, 1'b1, 0, 8, 1, 0, 32'hDEADBEEF});

    // Reset in the middle of the third byte discards the partial word.
    apply('{8'hAA, 1'b1, 0, 0, 0, 0, 32'hDEADBEEF});
    apply('{8'hBB, 1'b1, 0, 0, 0, 0, 32'hDEADBEEF});
    rxd = 1'b0;
    repeat (2 * H) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * H) @(negedge clk);
    rxd = 1'b0;
    repeat (2 * H) @(negedge clk);
    reset = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_ready", {31'd0, rdata_ready}, 32'd0);
    check("midreset_ferr", {31'd0, ferr}, 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    apply('{8'hBE, 1'b1, 0, 8, 0, 0, 32'h0});
    apply('{8'hBA, 1'b1, 0, 8, 0, 0, 32'h0});
    apply('{8'hFE, 1'b1, 0, 8, 0, 0, 32'h0});
    apply('{8'hCA, 1'b1, 0, 8, 1, 0, 32'hCAFEBABE});

    // Random frames against a byte-queue model of word assembly.
    model_q.delete();
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.data      = 8'($urandom);
      v.stop      = ($urandom_range(0, 7) != 0);
      v.skew      = $urandom_range(0, 2) - 1;
      v.gap       = v.stop ? $urandom_range(0, 20) : $urandom_range(16, 24);
      v.exp_ready = 0;
      v.exp_ferr  = 0;
      v.exp_word  = cur_word;
      if (v.stop) begin
        model_q.push_back(v.data);
        if (model_q.size() == 4) begin
          for (int k = 0; k < 4; k++) cb[k] = model_q[k];
          v.exp_word  = {cb[3], cb[2], cb[1], cb[0]};
          v.exp_ready = 1;
          model_q.delete();
        end
      end else begin
        v.exp_ferr = 1;
        model_q.delete();
      end
      apply(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
